// File: rtl/sram_req_bridge_if.sv
// Client and SRAM22-macro signal bundle for sram_req_bridge.
// The slave modport is the bridge; the master modport is the client plus the macro.
interface sram_req_bridge_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WMASK_WIDTH = 1
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DATA_WIDTH-1:0]  resp_rdata;
  logic                   sram_we;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, sram_dout,
    output req_ready, resp_valid, resp_rdata, sram_we, sram_wmask, sram_addr, sram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, sram_dout,
    input  req_ready, resp_valid, resp_rdata, sram_we, sram_wmask, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_req_bridge.sv
// Valid/ready front-end for a single-port SRAM22 macro with a credit-guarded
// response FIFO capturing read data one cycle after each accepted read.
module sram_req_bridge #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WMASK_WIDTH = 1,
  parameter int unsigned RESP_DEPTH  = 3
) (
  input logic              clk,
  input logic              rst,
  sram_req_bridge_if.slave bus
);
  localparam int unsigned CntW  = $clog2(RESP_DEPTH + 1);
  localparam int unsigned CntW1 = CntW + 1;
  localparam int unsigned PtrW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PtrW-1:0]  PtrMax   = PtrW'(RESP_DEPTH - 1);
  localparam logic [CntW1-1:0] DepthExt = CntW1'(RESP_DEPTH);

  logic                  fire;
  logic                  push;
  logic                  pop;
  logic                  rd_pending_q;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];

  // Ready counts the in-flight read as occupied so its data always has a slot.
  always_comb begin
    bus.req_ready  = !rst && (({1'b0, count_q} + {{CntW{1'b0}}, rd_pending_q}) < DepthExt);
    fire           = bus.req_valid && bus.req_ready;
    bus.sram_we    = fire && bus.req_we;
    bus.sram_wmask = bus.sram_we ? {WMASK_WIDTH{1'b1}} : {WMASK_WIDTH{1'b0}};
    bus.sram_addr  = bus.req_addr;
    bus.sram_din   = bus.req_wdata;
    bus.resp_valid = (count_q != '0);
    bus.resp_rdata = mem_q[rd_ptr_q];
    push           = rd_pending_q;
    pop            = bus.resp_valid && bus.resp_ready;
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_q <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      rd_pending_q <= fire && !bus.req_we;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RESP_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.sram_dout;
    end
  end
endmodule

// File: tb/tb_sram_req_bridge.sv
// Directed and random checks of sram_req_bridge against a behavioural SRAM22
// macro and a reference memory/response-queue model.
module tb_sram_req_bridge;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
  localparam int unsigned MW = 1;
  localparam int unsigned RESP_DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   nreads = 0;

  sram_req_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

  sram_req_bridge #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WMASK_WIDTH(MW),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural macro: write when we, otherwise read with one-cycle latency.
  logic [DW-1:0] macro_mem [512] = '{default: 32'h0};
  logic [DW-1:0] dout_q = '0;
  always @(posedge clk) begin
    if (bus.sram_we && bus.sram_wmask[0]) macro_mem[bus.sram_addr] <= bus.sram_din;
    else if (!bus.sram_we) dout_q <= macro_mem[bus.sram_addr];
  end
  assign bus.sram_dout = dout_q;

  logic [DW-1:0] ref_mem [512] = '{default: 32'h0};
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard: record accepts, check every popped response and FIFO overflow.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
        else begin
          exp_q.push_back(ref_mem[bus.req_addr]);
          nreads++;
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        chk("resp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk("resp_data", bus.resp_rdata, exp_q.pop_front());
      end
      chk("fifo_overflow", {31'd0, dut.rd_pending_q && int'(dut.count_q) == RESP_DEPTH &&
                                   !(bus.resp_valid && bus.resp_ready)}, 32'd0);
    end
  end

  initial begin
    int addr_n;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 9'h010;
    bus.req_wdata  = 32'hCAFEF00D;
    bus.resp_ready = 1'b0;

    // Reset with a request pending
    repeat (2) tick();
    sample();
    chk("rst_sram_we", {31'd0, bus.sram_we}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    tick();
    rst = 1'b0;
    bus.req_valid = 1'b0;
    sample();
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();

    // Write then read same address
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 9'h1A5;
    bus.req_wdata  = 32'hDEADBEEF;
    sample();
    chk("wr_sram_we", {31'd0, bus.sram_we}, 32'd1);
    chk("wr_wmask", {31'd0, bus.sram_wmask}, 32'd1);
    chk("wr_sram_addr", {23'd0, bus.sram_addr}, 32'h1A5);
    tick();
    bus.req_we = 1'b0;
    sample();
    chk("rd_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rd_sram_we", {31'd0, bus.sram_we}, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    sample();
    chk("rd_lat1_valid", {31'd0, bus.resp_valid}, 32'd0);
    tick();
    sample();
    chk("rd_lat2_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("rd_lat2_data", bus.resp_rdata, 32'hDEADBEEF);
    tick();
    sample();
    chk("rd_single_resp", {31'd0, bus.resp_valid}, 32'd0);
    tick();

    // Streaming: fill addrs 0..7, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = AW'(i);
      bus.req_wdata = 32'(i) * 32'h11111111;
      sample();
      chk("stream_wr_ready", {31'd0, bus.req_ready}, 32'd1);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = (k < 8);
      bus.req_we    = 1'b0;
      bus.req_addr  = AW'(k % 8);
      sample();
      if (k < 8) chk("stream_rd_ready", {31'd0, bus.req_ready}, 32'd1);
      if (k >= 2) begin
        chk("stream_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("stream_data", bus.resp_rdata, 32'(k - 2) * 32'h11111111);
      end
      tick();
    end
    sample();
    chk("stream_done", {31'd0, bus.resp_valid}, 32'd0);
    tick();

    // Backpressure: reads of addrs 0..5 with resp_ready low
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.req_addr = AW'(c);
      sample();
      chk("bp_accept", {31'd0, bus.req_ready}, 32'd1);
      tick();
    end
    addr_n = 3;
    bus.req_addr = AW'(addr_n);
    sample();
    chk("bp_stall_c3", {31'd0, bus.req_ready}, 32'd0);
    chk("bp_valid_c3", {31'd0, bus.resp_valid}, 32'd1);
    tick();
    sample();
    chk("bp_stall_c4", {31'd0, bus.req_ready}, 32'd0);
    chk("bp_head_c4", bus.resp_rdata, 32'd0);
    tick();
    bus.resp_ready = 1'b1;
    sample();
    chk("bp_stall_c5", {31'd0, bus.req_ready}, 32'd0);
    chk("bp_head_c5", bus.resp_rdata, 32'd0);
    tick();
    sample();
    chk("bp_ready_after_pop", {31'd0, bus.req_ready}, 32'd1);
    chk("bp_head_c6", bus.resp_rdata, 32'h11111111);
    if (bus.req_ready) addr_n++;
    tick();
    for (int i = 0; i < 20 && addr_n < 6; i++) begin
      bus.req_addr = AW'(addr_n);
      sample();
      if (bus.req_ready) addr_n++;
      tick();
    end
    chk("bp_resume_done", 32'(addr_n), 32'd6);
    bus.req_valid = 1'b0;
    repeat (6) tick();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    sample();
    chk("bp_idle_valid", {31'd0, bus.resp_valid}, 32'd0);
    tick();

    // Reset with a read in flight
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 9'd3;
    sample();
    chk("inflight_accept", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    sample();
    chk("inflight_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("inflight_rst_pend", {31'd0, dut.rd_pending_q}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("inflight_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      tick();
    end
    chk("inflight_count", 32'(dut.count_q), 32'd0);

    // Random mix against the reference model
    nreads = 0;
    for (int i = 0; i < 10000; i++) begin
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      bus.req_valid  = ($urandom_range(0, 1) != 0);
      bus.req_we     = ($urandom_range(0, 2) == 0);
      bus.req_addr   = AW'($urandom_range(0, 15));
      bus.req_wdata  = $urandom;
      tick();
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (8) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_activity", {31'd0, nreads > 1000}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
